note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Playback controller for the player piano: steps through a song ROM of (keycode, duration) entries and drives the KeyCode/Enable pair consumed by the decoder-and-synth path.
- Arbitrates between stored-song playback and live keyboard input; live input always wins.
- Sits between the song ROM and user controls on one side and the sound decoder/synthesizer on the other.

Parameters:
- CLK_HZ, 100000000, system clock frequency.
- TICK_HZ, 100, duration unit rate (one tick = 10 ms at default).
- ADDR_W, 6, ROM address width; song depth is 2**ADDR_W entries.
- GAP_TICKS, 2, silent ticks inserted after every note. Must be >= 1.

Ports:
- Clock  in  1  system clock.
- btnCpuReset  in  1  synchronous reset, active-low.
- Play  in  1  start song from address 0; level-sampled each cycle.
- Stop  in  1  abort playback.
- LiveKeyCode  in  8  keycode from the keyboard path.
- LiveValid  in  1  live key held.
- RomAddr  out  ADDR_W  song ROM address.
- RomData  in  16  [15:8] keycode, [7:0] duration in ticks. Synchronous ROM with 1-cycle read latency.
- KeyCode  out  8  keycode to the decoder.
- Enable  out  1  sound enable to the decoder.
- Busy  out  1  song in progress (any state except IDLE).
- Done  out  1  one-cycle pulse on normal song completion.

Behaviour:
- Reset (btnCpuReset=0 at an edge): state IDLE; RomAddr=0, KeyCode=0, Enable=0, Busy=0, Done=0; tick divider and duration counter cleared. Reset mid-song returns all outputs to 0 at that edge.
- Tick divider:
  - DIV = CLK_HZ/TICK_HZ.
  - Counts 0..DIV-1; tick pulses when the count is DIV-1.
  - Cleared on entry to NOTE and to GAP, so each tick interval is exactly DIV cycles.
- States:
  - IDLE: Play=1 -> FETCH with RomAddr=0.
  - FETCH: one cycle; ROM address presented -> WAIT.
  - WAIT: RomData valid; capture keycode and duration.
    - Duration=0 is the end marker -> DONE.
    - Otherwise -> NOTE.
  - NOTE: lasts exactly duration*DIV cycles.
    - Keycode!=0: song KeyCode held with Enable=1.
    - Keycode=0: rest, Enable=0.
    - Exit -> GAP.
  - GAP: Enable=0 for GAP_TICKS*DIV cycles.
    - If RomAddr is the last address (2**ADDR_W-1) -> DONE.
    - Else increment RomAddr -> FETCH.
  - DONE: one cycle; Done=1, Enable=0 -> IDLE with RomAddr=0.
- Latency: with Play sampled at edge k, song Enable rises at edge k+3 (FETCH at k+1, WAIT at k+2, NOTE at k+3). Between notes there are GAP_TICKS*DIV+2 cycles with Enable low.
- Controls:
  - Play while Busy is ignored; it does not restart the song.
  - Stop in any non-IDLE state -> IDLE at the next edge with Enable=0, RomAddr=0, and no Done pulse.
  - Stop and Play asserted in the same cycle: Stop wins and the song does not start.
- Live override:
  - While LiveValid=1, KeyCode=LiveKeyCode and Enable=1, combinationally muxed after the sequencer registers.
  - The sequencer FSM and its counters freeze while LiveValid=1 and resume exactly where they left off when it drops.
  - Stop is still honoured during override.
  - In IDLE, live input passes through unchanged.
- Width rules: the duration counter is 8 bits; the tick-in-note comparison uses the captured duration; RomAddr increments modulo 2**ADDR_W and is only incremented when not at the last address.

Optional Feature:
- Macro NOTE_SEQ_LOOP_EN.
- Defined: an end marker, or the end of GAP at the last address, goes to FETCH with RomAddr=0 instead of DONE. The song loops until Stop, Busy stays 1, and Done never pulses.
- Undefined: behaviour exactly as above.

Decomposition:
- Shared package piano_pkg:
  - FSM state enum (IDLE, FETCH, WAIT, NOTE, GAP, DONE).
  - ROM field slice constants (KEY_MSB=15, KEY_LSB=8, DUR_MSB=7, DUR_LSB=0).
  - REST_KEY=8'h00 and END_DUR=8'h00.
- One sub-module, tick_gen: DIV counter with synchronous clear, freeze enable and tick output; reused by other timed blocks.

Test Plan (CLK_HZ=1000, TICK_HZ=100 -> DIV=10; GAP_TICKS=2; ADDR_W=3):
- ROM {1C/03, 1B/02, 00/00}, pulse Play at edge 0:
  - Enable=1 with KeyCode=8'h1C on edges 3..32 (30 cycles), then low for 22 cycles.
  - KeyCode=8'h1B with Enable=1 for 20 cycles.
  - After the second note's gap, Done pulses once and Busy falls.
- ROM {00/02, 23/01, 00/00}: Enable stays 0 for the 20-cycle rest; 8'h23 then plays for exactly 10 cycles.
- Assert Stop 5 cycles into the first note: Enable=0 and Busy=0 at the next edge, RomAddr=0, no Done. Play+Stop together in IDLE: Busy stays 0.
- LiveValid=1 with LiveKeyCode=8'h2B for 15 cycles mid-note:
  - KeyCode=8'h2B and Enable=1 throughout the override.
  - The song note then resumes, and total song-note high time is still 30 cycles.
- ROM of 8 entries with no end marker, each x/01:
  - Plays 8 notes and Done pulses after the 8th gap.
  - With NOTE_SEQ_LOOP_EN defined, the 9th note is entry 0 and Done never asserts.
- Assert btnCpuReset=0 mid-GAP: all outputs 0 at that edge. Play after release restarts from address 0 with first Enable at +3 edges.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared types and song-ROM field layout for the player-piano blocks.
package piano_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    NOTE  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  localparam int KEY_MSB = 15;
  localparam int KEY_LSB = 8;
  localparam int DUR_MSB = 7;
  localparam int DUR_LSB = 0;

  localparam logic [7:0] REST_KEY = 8'h00;
  localparam logic [7:0] END_DUR  = 8'h00;

endpackage

// File: rtl/tick_gen.sv
// Divide-by-DIV tick generator with synchronous clear and freeze enable.
// tick_o pulses on the last count of each DIV-cycle interval while enabled.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Song-ROM playback controller with live-keyboard override.
// Build option NOTE_SEQ_LOOP_EN: the song wraps to address 0 instead of finishing.
module note_sequencer
  import piano_pkg::*;
#(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 100,
  parameter int ADDR_W    = 6,
  parameter int GAP_TICKS = 2
) (
  input  logic              Clock,
  input  logic              btnCpuReset,
  input  logic              Play,
  input  logic              Stop,
  input  logic [7:0]        LiveKeyCode,
  input  logic              LiveValid,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [15:0]       RomData,
  output logic [7:0]        KeyCode,
  output logic              Enable,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        DbgState
);

  localparam int                DIV       = CLK_HZ / TICK_HZ;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [7:0]        GAP_LAST  = 8'(GAP_TICKS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        key_q, key_d;
  logic [7:0]        dur_q, dur_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              tick_clr;
  logic              tick;
  logic              song_on;

  // Live input freezes the divider together with the FSM so a note resumes exactly.
  tick_gen #(.DIV(DIV)) u_tick (
    .clk_i  (Clock),
    .rst_ni (btnCpuReset),
    .clr_i  (tick_clr),
    .en_i   (!LiveValid),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    key_d    = key_q;
    dur_d    = dur_q;
    tcnt_d   = tcnt_q;
    tick_clr = 1'b0;
    if (Stop && state_q != IDLE) begin
      state_d  = IDLE;
      addr_d   = '0;
      tcnt_d   = '0;
      tick_clr = 1'b1;
    end else if (!LiveValid) begin
      case (state_q)
        IDLE: begin
          if (Play && !Stop) begin
            state_d = FETCH;
            addr_d  = '0;
          end
        end
        FETCH: state_d = WAIT;
        WAIT: begin
          key_d = RomData[KEY_MSB:KEY_LSB];
          dur_d = RomData[DUR_MSB:DUR_LSB];
          if (RomData[DUR_MSB:DUR_LSB] == END_DUR) begin
`ifdef NOTE_SEQ_LOOP_EN
            state_d = FETCH;
            addr_d  = '0;
`else
            state_d = DONE;
`endif
          end else begin
            state_d  = NOTE;
            tcnt_d   = '0;
            tick_clr = 1'b1;
          end
        end
        NOTE: begin
          if (tick) begin
            if (tcnt_q == dur_q - 8'd1) begin
              state_d  = GAP;
              tcnt_d   = '0;
              tick_clr = 1'b1;
            end else begin
              tcnt_d = tcnt_q + 8'd1;
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (tcnt_q == GAP_LAST) begin
              tcnt_d = '0;
              if (addr_q == LAST_ADDR) begin
`ifdef NOTE_SEQ_LOOP_EN
                state_d = FETCH;
                addr_d  = '0;
`else
                state_d = DONE;
`endif
              end else begin
                state_d = FETCH;
                addr_d  = addr_q + ADDR_W'(1);
              end
            end else begin
              tcnt_d = tcnt_q + 8'd1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          addr_d  = '0;
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!btnCpuReset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      key_q   <= '0;
      dur_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      key_q   <= key_d;
      dur_q   <= dur_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Live keyboard is muxed after the registers so it reaches the decoder immediately.
  assign song_on  = (state_q == NOTE);
  assign KeyCode  = LiveValid ? LiveKeyCode : (song_on ? key_q : 8'h00);
  assign Enable   = LiveValid | (song_on && key_q != REST_KEY);
  assign RomAddr  = addr_q;
  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == DONE);
  assign DbgState = state_q;

endmodule
